// File: rtl/rvfi_pipe_tracker_if.sv
// Bundle between the core pipeline controls and the RVFI shadow pipeline.
// The core side drives the master modport; the tracker takes the slave modport.
interface rvfi_pipe_tracker_if #(
  parameter int unsigned STAGES  = 4,
  parameter int unsigned PKT_W   = 256,
  parameter int unsigned ORDER_W = 64
);
  logic                in_valid;
  logic [PKT_W-1:0]    in_pkt;
  logic [31:0]         in_pc_rdata;
  logic [31:0]         in_pc_wdata;
  logic [4:0]          in_rd_addr;
  logic [STAGES-1:0]   stage_load;
  logic [STAGES-1:0]   stage_flush;
  logic [31:0]         wb_rd_wdata;

  logic [STAGES-1:0]   stage_valid;
  logic                out_commit;
  logic [ORDER_W-1:0]  out_order;
  logic [PKT_W-1:0]    out_pkt;
  logic [31:0]         out_pc_rdata;
  logic [31:0]         out_pc_wdata;
  logic [4:0]          out_rd_addr;
  logic [31:0]         out_rd_wdata;
  logic                out_halt;
  logic                err_pc_mismatch;

  modport master (
    output in_valid, in_pkt, in_pc_rdata, in_pc_wdata, in_rd_addr,
           stage_load, stage_flush, wb_rd_wdata,
    input  stage_valid, out_commit, out_order, out_pkt, out_pc_rdata,
           out_pc_wdata, out_rd_addr, out_rd_wdata, out_halt, err_pc_mismatch
  );

  modport slave (
    input  in_valid, in_pkt, in_pc_rdata, in_pc_wdata, in_rd_addr,
           stage_load, stage_flush, wb_rd_wdata,
    output stage_valid, out_commit, out_order, out_pkt, out_pc_rdata,
           out_pc_wdata, out_rd_addr, out_rd_wdata, out_halt, err_pc_mismatch
  );
endinterface

// File: rtl/rvfi_pipe_tracker.sv
// RVFI shadow pipeline: one monitor packet per in-flight instruction, moved in lockstep
// with the core's stage loads/flushes; the last stage drives commit, order, PC and halt checks.
module rvfi_pipe_tracker #(
  parameter int unsigned STAGES  = 4,
  parameter int unsigned PKT_W   = 256,
  parameter int unsigned ORDER_W = 64
) (
  input logic               clk,
  input logic               rst,
  rvfi_pipe_tracker_if.slave bus
);
  localparam int unsigned LAST = STAGES - 1;

  typedef struct packed {
    logic [PKT_W-1:0] pkt;
    logic [31:0]      pc_r;
    logic [31:0]      pc_w;
    logic [4:0]       rd;
  } ent_t;

  typedef enum logic {CHK_FIRST, CHK_ARMED} chk_state_t;

  ent_t               ent_q [STAGES];
  ent_t               in_ent;
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  cap_valid;
  logic               fresh_q;
  logic               commit;
  logic [ORDER_W-1:0] order_q;
  logic [31:0]        last_wdata_q;
  logic               halt_q;
  logic               err_q;
  chk_state_t         chk_q, chk_d;
  logic               pc_break;

  assign in_ent = '{pkt: bus.in_pkt, pc_r: bus.in_pc_rdata, pc_w: bus.in_pc_wdata,
                    rd: bus.in_rd_addr};

  // Valid bit a stage would capture: a flushed upstream entry must not slip forward.
  assign cap_valid[0] = bus.in_valid & ~bus.stage_flush[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q[0] <= 1'b0;
      ent_q[0]   <= '0;
    end else if (bus.stage_load[0]) begin
      valid_q[0] <= cap_valid[0];
      ent_q[0]   <= in_ent;
    end else if (bus.stage_flush[0]) begin
      valid_q[0] <= 1'b0;
    end
  end

  for (genvar g = 1; g < STAGES; g++) begin : g_stage
    assign cap_valid[g] = bus.stage_load[g-1] & valid_q[g-1]
                        & ~bus.stage_flush[g-1] & ~bus.stage_flush[g];

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q[g] <= 1'b0;
        ent_q[g]   <= '0;
      end else if (bus.stage_load[g]) begin
        valid_q[g] <= cap_valid[g];
        ent_q[g]   <= ent_q[g-1];
      end else if (bus.stage_flush[g]) begin
        valid_q[g] <= 1'b0;
      end
    end
  end

  // fresh marks the single cycle after the last stage took a valid entry.
  always_ff @(posedge clk) begin
    if (rst) fresh_q <= 1'b0;
    else     fresh_q <= bus.stage_load[LAST] & cap_valid[LAST];
  end

  assign commit = valid_q[LAST] & fresh_q & ~rst;

  always_comb begin
    chk_d    = chk_q;
    pc_break = 1'b0;
    if (commit) begin
      chk_d    = CHK_ARMED;
      pc_break = (chk_q == CHK_ARMED) && (ent_q[LAST].pc_r != last_wdata_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) chk_q <= CHK_FIRST;
    else     chk_q <= chk_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      order_q      <= '0;
      last_wdata_q <= '0;
      halt_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (commit) begin
      order_q      <= order_q + 1'b1;
      last_wdata_q <= ent_q[LAST].pc_w;
      if (ent_q[LAST].pc_r == ent_q[LAST].pc_w) halt_q <= 1'b1;
      if (pc_break) err_q <= 1'b1;
    end
  end

  assign bus.stage_valid     = valid_q;
  assign bus.out_commit      = commit;
  assign bus.out_order       = order_q;
  assign bus.out_pkt         = ent_q[LAST].pkt;
  assign bus.out_pc_rdata    = ent_q[LAST].pc_r;
  assign bus.out_pc_wdata    = ent_q[LAST].pc_w;
  assign bus.out_rd_addr     = ent_q[LAST].rd;
  assign bus.out_rd_wdata    = (ent_q[LAST].rd != 5'd0) ? bus.wb_rd_wdata : '0;
  assign bus.out_halt        = halt_q;
  assign bus.err_pc_mismatch = err_q;
endmodule

// File: tb/tb_rvfi_pipe_tracker.sv
// Bench for rvfi_pipe_tracker: instruction-identity model checked every cycle,
// plus literal expectations on the observed commit log.
module tb_rvfi_pipe_tracker;
  localparam int ST = 4;
  localparam int PW = 16;
  localparam int OW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rvfi_pipe_tracker_if #(.STAGES(ST), .PKT_W(PW), .ORDER_W(OW)) bus ();

  rvfi_pipe_tracker #(.STAGES(ST), .PKT_W(PW), .ORDER_W(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each captured instruction gets a unique id; a commit is a valid
  // last-stage entry whose id has not retired before.
  typedef struct {
    bit        v;
    int        id;
    bit [31:0] pr;
    bit [31:0] pw;
    bit [4:0]  rd;
    bit [15:0] pkt;
  } ment_t;

  typedef struct {
    bit [31:0] pc;
    bit [3:0]  ord;
    bit [31:0] rdw;
  } log_t;

  ment_t     m [ST];
  int        next_id = 0;
  int        last_id = -1;
  int        m_order = 0;
  bit        m_halt, m_err, have_prev, started;
  bit [31:0] prev_w;
  log_t      lg [$];

  always @(posedge clk) begin : model
    ment_t n [ST];
    if (rst) begin
      foreach (m[i]) m[i] = '{v: 1'b0, id: -1, pr: '0, pw: '0, rd: '0, pkt: '0};
      m_order = 0; m_halt = 0; m_err = 0; have_prev = 0; started = 1;
    end else begin
      if (m[ST-1].v && m[ST-1].id != last_id) begin
        if (have_prev && m[ST-1].pr != prev_w) m_err = 1;
        if (m[ST-1].pr == m[ST-1].pw) m_halt = 1;
        prev_w    = m[ST-1].pw;
        have_prev = 1;
        last_id   = m[ST-1].id;
        m_order   = (m_order + 1) % (1 << OW);
      end
      n = m;
      if (bus.stage_load[0]) begin
        n[0] = '{v: bus.in_valid && !bus.stage_flush[0], id: next_id, pr: bus.in_pc_rdata,
                 pw: bus.in_pc_wdata, rd: bus.in_rd_addr, pkt: bus.in_pkt};
        next_id++;
      end else if (bus.stage_flush[0]) begin
        n[0].v = 0;
      end
      for (int i = 1; i < ST; i++) begin
        if (bus.stage_load[i]) begin
          n[i]   = m[i-1];
          n[i].v = bus.stage_load[i-1] && m[i-1].v && !bus.stage_flush[i-1] && !bus.stage_flush[i];
        end else if (bus.stage_flush[i]) begin
          n[i].v = 0;
        end
      end
      m = n;
    end
  end

  always @(negedge clk) begin : compare
    bit          ec;
    bit [ST-1:0] ev;
    if (started) begin
      ec = !rst && m[ST-1].v && (m[ST-1].id != last_id);
      for (int i = 0; i < ST; i++) ev[i] = m[i].v;
      check("stage_valid", bus.stage_valid, ev);
      check("out_commit", bus.out_commit, ec);
      check("out_order", bus.out_order, m_order);
      check("out_halt", bus.out_halt, m_halt);
      check("err_pc_mismatch", bus.err_pc_mismatch, m_err);
      if (m[ST-1].v) begin
        check("out_pc_rdata", bus.out_pc_rdata, m[ST-1].pr);
        check("out_pc_wdata", bus.out_pc_wdata, m[ST-1].pw);
        check("out_rd_addr", bus.out_rd_addr, m[ST-1].rd);
        check("out_pkt", bus.out_pkt, m[ST-1].pkt);
        check("out_rd_wdata", bus.out_rd_wdata,
              (m[ST-1].rd != 0) ? bus.wb_rd_wdata : 32'h0);
      end
      if (bus.out_commit)
        lg.push_back('{pc: bus.out_pc_rdata, ord: bus.out_order, rdw: bus.out_rd_wdata});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input bit [31:0] pr, input bit [31:0] pw,
                       input bit [4:0] rd, input bit [3:0] ld, input bit [3:0] fl);
    bus.in_valid    = v;
    bus.in_pc_rdata = pr;
    bus.in_pc_wdata = pw;
    bus.in_rd_addr  = rd;
    bus.in_pkt      = pr[15:0] ^ 16'hA5A5;
    bus.stage_load  = ld;
    bus.stage_flush = fl;
  endtask

  task automatic issue(input bit [31:0] pr, input bit [31:0] pw, input bit [4:0] rd);
    drive(1'b1, pr, pw, rd, 4'hF, 4'h0);
    tick();
  endtask

  task automatic idle(input int n, input bit [3:0] ld);
    drive(1'b0, '0, '0, '0, ld, 4'h0);
    repeat (n) tick();
  endtask

  task automatic pin_log(input int k, input bit [31:0] pc, input bit [3:0] ord);
    if (lg.size() > k) begin
      check($sformatf("log%0d_pc", k), lg[k].pc, pc);
      check($sformatf("log%0d_order", k), lg[k].ord, ord);
    end else begin
      check($sformatf("log%0d_present", k), lg.size(), k + 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.wb_rd_wdata = 32'h1234_5678;
    drive(1'b0, '0, '0, '0, 4'hF, 4'h0);
    repeat (2) tick();
    rst = 1'b0;
    check("reset_stage_valid", bus.stage_valid, 4'b0000);
    check("reset_order", bus.out_order, 4'd0);

    // In-order stream
    issue(32'h60, 32'h64, 5'd1);
    issue(32'h64, 32'h68, 5'd2);
    issue(32'h68, 32'h6C, 5'd3);
    idle(6, 4'hF);
    check("t1_commits", lg.size(), 3);
    pin_log(0, 32'h60, 4'd0);
    pin_log(2, 32'h68, 4'd2);
    if (lg.size() > 0) check("t1_rd_wdata", lg[0].rdw, 32'h1234_5678);

    // Last stage held after commit
    issue(32'h6C, 32'h70, 5'd4);
    idle(3, 4'hF);
    idle(5, 4'b0111);
    check("t2_commits", lg.size(), 4);
    check("t2_order_held", bus.out_order, 4'd4);
    idle(2, 4'hF);

    // Taken branch flushes the two younger wrong-path entries
    issue(32'h70, 32'h80, 5'd5);
    issue(32'h74, 32'h78, 5'd6);
    issue(32'h78, 32'h7C, 5'd7);
    drive(1'b0, '0, '0, '0, 4'hF, 4'b0011);
    tick();
    issue(32'h80, 32'h84, 5'd8);
    idle(5, 4'hF);
    check("t4_commits", lg.size(), 6);
    pin_log(4, 32'h70, 4'd4);
    pin_log(5, 32'h80, 4'd5);
    check("t4_err", bus.err_pc_mismatch, 1'b0);

    // Stage 1 stalled for two cycles while downstream drains
    issue(32'h84, 32'h100, 5'd9);
    idle(1, 4'hF);
    idle(2, 4'b1101);
    check("t3_stalled_valid", bus.stage_valid, 4'b0010);
    idle(5, 4'hF);
    check("t3_commits", lg.size(), 7);
    pin_log(6, 32'h84, 4'd6);

    // PC discontinuity
    issue(32'h100, 32'h104, 5'd10);
    issue(32'h200, 32'h204, 5'd11);
    idle(6, 4'hF);
    check("t5_err_set", bus.err_pc_mismatch, 1'b1);
    pin_log(8, 32'h200, 4'd8);
    idle(3, 4'hF);
    check("t5_err_sticky", bus.err_pc_mismatch, 1'b1);

    // Reset with an instruction in flight
    issue(32'h300, 32'h304, 5'd12);
    idle(1, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_err_clear", bus.err_pc_mismatch, 1'b0);
    check("rst_order_clear", bus.out_order, 4'd0);
    idle(5, 4'hF);
    check("rst_no_commit", lg.size(), 9);

    // Order wrap and halt on self-loop
    bus.wb_rd_wdata = 32'hDEAD;
    for (int k = 0; k < 15; k++)
      issue(32'h1B4 + 4 * k, 32'h1B8 + 4 * k, 5'(k + 1));
    issue(32'h1F0, 32'h1F0, 5'd0);
    issue(32'h1F0, 32'h1F0, 5'd0);
    idle(6, 4'hF);
    check("t6_commits", lg.size(), 26);
    pin_log(9, 32'h1B4, 4'd0);
    pin_log(24, 32'h1F0, 4'd15);
    pin_log(25, 32'h1F0, 4'd0);
    if (lg.size() > 24) check("t6_rd_wdata_x0", lg[24].rdw, 32'h0);
    check("t6_halt", bus.out_halt, 1'b1);
    check("t6_err", bus.err_pc_mismatch, 1'b0);
    check("t6_order_after_wrap", bus.out_order, 4'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
